// File: rtl/dmem_arb.sv
// Two-requester arbiter for a single data-memory port: round-robin grant with a
// bounded burst lock, and read-return valid tagged to the beat's owner.
module dmem_arb #(
    parameter int ADDR_W   = 24,
    parameter int DATA_W   = 24,
    parameter int MAX_HOLD = 4
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic [1:0]            iw_req,
    input  logic [1:0]            iw_lock,
    input  logic [1:0]            iw_we,
    input  logic [2*ADDR_W-1:0]   iw_addr,
    input  logic [2*DATA_W-1:0]   iw_wdata,
    output logic [1:0]            ow_gnt,
    output logic [1:0]            or_rvalid,
    output logic [DATA_W-1:0]     ow_rdata,
    output logic                  ow_mem_we,
    output logic [ADDR_W-1:0]     ow_mem_addr,
    output logic [DATA_W-1:0]     ow_mem_wdata,
    input  logic [DATA_W-1:0]     iw_mem_rdata
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    logic       r_last_q, r_last_d;
    logic [3:0] r_hold_q, r_hold_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       accept;

    always_comb begin
        gnt = 2'b00;
        if (!iw_rst) begin
            unique case (iw_req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11: begin
                    // The lock only counts for the current owner, and only until the hold budget runs out.
                    if (iw_lock[r_last_q] && (r_hold_q < HOLD_MAX))
                        gnt = r_last_q ? 2'b10 : 2'b01;
                    else
                        gnt = r_last_q ? 2'b01 : 2'b10;
                end
                default: gnt = 2'b00;
            endcase
        end
    end

    assign gnt_idx = gnt[1];
    assign accept  = |gnt;

    always_comb begin
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (accept) begin
            ow_mem_we    = iw_we[gnt_idx];
            ow_mem_addr  = iw_addr[gnt_idx*ADDR_W +: ADDR_W];
            ow_mem_wdata = iw_wdata[gnt_idx*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        r_last_d = r_last_q;
        r_hold_d = 4'd0;
        rvalid_d = 2'b00;
        if (accept) begin
            r_last_d = gnt_idx;
            if (gnt_idx == r_last_q)
                r_hold_d = (r_hold_q >= HOLD_MAX) ? HOLD_MAX : r_hold_q + 4'd1;
            else
                r_hold_d = 4'd1;
            if (!iw_we[gnt_idx])
                rvalid_d = gnt;
        end
    end

    // Reset leaves r_last pointing at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_last_q <= 1'b1;
            r_hold_q <= 4'd0;
            rvalid_q <= 2'b00;
        end else begin
            r_last_q <= r_last_d;
            r_hold_q <= r_hold_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign ow_gnt    = gnt;
    assign or_rvalid = rvalid_q;
    assign ow_rdata  = iw_mem_rdata;

endmodule

// File: tb/tb_dmem_arb.sv
// Randomized and directed bench for dmem_arb against a behavioural arbitration
// and memory model; a small synchronous RAM stands in for the memory port.
module tb_dmem_arb;

    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 24;
    localparam int MAX_HOLD = 4;

    logic                iw_clk = 1'b0;
    logic                iw_rst;
    logic [1:0]          iw_req, iw_lock, iw_we;
    logic [2*ADDR_W-1:0] iw_addr;
    logic [2*DATA_W-1:0] iw_wdata;
    logic [1:0]          ow_gnt, or_rvalid;
    logic [DATA_W-1:0]   ow_rdata;
    logic                ow_mem_we;
    logic [ADDR_W-1:0]   ow_mem_addr;
    logic [DATA_W-1:0]   ow_mem_wdata;
    logic [DATA_W-1:0]   iw_mem_rdata;

    dmem_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_req(iw_req), .iw_lock(iw_lock),
        .iw_we(iw_we), .iw_addr(iw_addr), .iw_wdata(iw_wdata), .ow_gnt(ow_gnt),
        .or_rvalid(or_rvalid), .ow_rdata(ow_rdata), .ow_mem_we(ow_mem_we),
        .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
        .iw_mem_rdata(iw_mem_rdata)
    );

    always #5 iw_clk = ~iw_clk;

    // Environment RAM: 256 words, 1-cycle synchronous read.
    logic [DATA_W-1:0] env_mem [256];
    always @(posedge iw_clk) begin
        if (ow_mem_we) env_mem[ow_mem_addr[7:0]] <= ow_mem_wdata;
        iw_mem_rdata <= env_mem[ow_mem_addr[7:0]];
    end

    // Reference model state
    logic [DATA_W-1:0] model_mem [256];
    int                m_last, m_hold;
    logic [1:0]        m_rv;
    logic [DATA_W-1:0] m_rd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [1:0] req, input logic [1:0] lock);
        if (req == 2'b00) return -1;
        if (req == 2'b01) return 0;
        if (req == 2'b10) return 1;
        if (lock[m_last] && m_hold < MAX_HOLD) return m_last;
        return 1 - m_last;
    endfunction

    // One cycle: drive after negedge, check combinational outputs, step the model
    // at posedge, then check the read return.
    task automatic step(input logic [1:0] req, input logic [1:0] lock, input logic [1:0] we,
                        input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input int plan_gnt);
        int g;
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd;
        iw_req = req; iw_lock = lock; iw_we = we;
        iw_addr = {a1, a0}; iw_wdata = {d1, d0};
        #1;
        g  = model_pick(req, lock);
        ga = (g == 1) ? a1 : a0;
        gd = (g == 1) ? d1 : d0;
        check("gnt", 64'(ow_gnt), (g < 0) ? 64'd0 : 64'(1 << g));
        if (plan_gnt >= 0) check("plan_gnt", 64'(ow_gnt), 64'(plan_gnt));
        check("mem_we", 64'(ow_mem_we), (g < 0) ? 64'd0 : 64'(we[g]));
        check("mem_addr", 64'(ow_mem_addr), (g < 0) ? 64'd0 : 64'(ga));
        check("mem_wdata", 64'(ow_mem_wdata), (g < 0) ? 64'd0 : 64'(gd));
        @(posedge iw_clk);
        m_rv = 2'b00;
        if (g < 0) begin
            m_hold = 0;
        end else begin
            m_hold = (g == m_last) ? ((m_hold + 1 > MAX_HOLD) ? MAX_HOLD : m_hold + 1) : 1;
            m_last = g;
            if (we[g]) begin
                model_mem[ga[7:0]] = gd;
            end else begin
                m_rv = 2'(1 << g);
                m_rd = model_mem[ga[7:0]];
            end
        end
        #1;
        check("rvalid", 64'(or_rvalid), 64'(m_rv));
        if (m_rv != 2'b00) check("rdata", 64'(ow_rdata), 64'(m_rd));
        @(negedge iw_clk);
    endtask

    task automatic model_reset();
        m_last = 1;
        m_hold = 0;
        m_rv   = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = 24'($urandom);
            model_mem[i] = env_mem[i];
        end
        iw_rst = 1'b1; iw_req = 2'b11; iw_lock = 2'b00; iw_we = 2'b00;
        iw_addr = '0; iw_wdata = '0;
        model_reset();
        repeat (2) @(posedge iw_clk);
        #1;
        check("rst_gnt", 64'(ow_gnt), 64'd0);
        check("rst_rvalid", 64'(or_rvalid), 64'd0);
        check("rst_mem_we", 64'(ow_mem_we), 64'd0);
        @(negedge iw_clk);
        iw_rst = 1'b0;

        // Single read by requester 0
        step(2'b01, 2'b00, 2'b00, 24'h000010, 24'h000000, 24'h0, 24'h0, 1);
        check("first_rdata", 64'(ow_rdata), 64'(env_mem[8'h10]));
        // Requester 1 alone, leaving requester 1 as last owner
        step(2'b10, 2'b00, 2'b00, 24'h000000, 24'h000031, 24'h0, 24'h0, 2);
        // Round-robin alternation
        step(2'b11, 2'b00, 2'b00, 24'h000001, 24'h000002, 24'h0, 24'h0, 1);
        step(2'b11, 2'b00, 2'b00, 24'h000003, 24'h000004, 24'h0, 24'h0, 2);
        step(2'b11, 2'b00, 2'b00, 24'h000005, 24'h000006, 24'h0, 24'h0, 1);
        step(2'b11, 2'b00, 2'b00, 24'h000007, 24'h000008, 24'h0, 24'h0, 2);
        step(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h0, 24'h0, 0);
        // Locked burst by requester 0, capped at MAX_HOLD beats
        for (int i = 0; i < 4; i++)
            step(2'b11, 2'b01, 2'b00, 24'(8'h40 + i), 24'h000050, 24'h0, 24'h0, 1);
        step(2'b11, 2'b01, 2'b00, 24'h000044, 24'h000051, 24'h0, 24'h0, 2);
        step(2'b11, 2'b00, 2'b00, 24'h000045, 24'h000052, 24'h0, 24'h0, 1);
        step(2'b00, 2'b00, 2'b00, 24'h0, 24'h0, 24'h0, 24'h0, 0);
        // Lock with no competitor saturates hold; competitor then wins at once
        for (int i = 0; i < 8; i++)
            step(2'b01, 2'b01, 2'b00, 24'(8'h60 + i), 24'h000070, 24'h0, 24'h0, 1);
        step(2'b11, 2'b01, 2'b00, 24'h000068, 24'h000071, 24'h0, 24'h0, 2);
        // Write by requester 1 then read-back by requester 0
        step(2'b10, 2'b00, 2'b10, 24'h000000, 24'h000020, 24'h0, 24'hABCDEF, 2);
        step(2'b01, 2'b00, 2'b00, 24'h000020, 24'h000000, 24'h0, 24'h0, 1);
        check("wr_readback", 64'(ow_rdata), 64'h0000_0000_00AB_CDEF);
        // Reset right after an accepted read
        step(2'b01, 2'b00, 2'b00, 24'h000033, 24'h000000, 24'h0, 24'h0, 1);
        iw_req = 2'b11;
        iw_rst = 1'b1;
        #1;
        check("midrst_rvalid", 64'(or_rvalid), 64'd0);
        check("midrst_gnt", 64'(ow_gnt), 64'd0);
        check("midrst_mem_we", 64'(ow_mem_we), 64'd0);
        @(posedge iw_clk);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        model_reset();
        step(2'b11, 2'b00, 2'b00, 24'h000011, 24'h000012, 24'h0, 24'h0, 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom), 2'($urandom), 2'($urandom),
                 24'($urandom_range(0, 255)), 24'($urandom_range(0, 255)),
                 24'($urandom), 24'($urandom), -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
